// File: rtl/ika2151_dac_deser.sv
// YM3012-style DAC front end: deserializes 13-bit float frames, latches on SH falls, decodes to 16-bit PCM.
// Define IKA2151_DAC_MONO_MIX_EN to add the registered o_MONO / o_MONO_VALID mix outputs.
module ika2151_dac_deser #(
    parameter bit EXP0_MUTE = 1'b1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    input  logic        i_ERR_CLR,
    output logic [15:0] o_L,
    output logic        o_L_VALID,
    output logic [15:0] o_R,
    output logic        o_R_VALID,
`ifdef IKA2151_DAC_MONO_MIX_EN
    output logic [15:0] o_MONO,
    output logic        o_MONO_VALID,
`endif
    output logic        o_FRAME_ERR
);

    localparam logic [4:0] CNT_MAX       = 5'd31;
    localparam logic [4:0] CNT_FRAME_MIN = 5'd12;

    // Mantissa is offset binary; flipping bit 9 gives the two's-complement value.
    function automatic logic [15:0] decode(input logic [12:0] frame);
        logic [2:0]  exp_v;
        logic [15:0] mant_v;
        logic [15:0] res;
        exp_v  = frame[12:10];
        mant_v = {{6{~frame[9]}}, ~frame[9], frame[8:0]};
        res    = '0;
        if (exp_v == 3'd0) begin
            res = EXP0_MUTE ? 16'd0 : mant_v;
        end else begin
            res = mant_v << (exp_v - 3'd1);
        end
        return res;
    endfunction

    logic              en;
    logic [1:0]        sh_in;
    logic [1:0]        fall;
    logic              any_fall;
    logic              accept;

    logic [12:0]       shift_q, shift_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        sh_q, sh_d;
    logic [1:0][12:0]  hold_q, hold_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0][15:0]  out_q, out_d;
    logic [1:0]        valid_q, valid_d;
    logic              err_q, err_d;

    assign en       = ~i_phi1_NCEN_n;
    assign sh_in    = {i_SH2, i_SH1};
    assign fall     = sh_q & ~sh_in & {2{en}};
    assign any_fall = |fall;
    assign accept   = (cnt_q >= CNT_FRAME_MIN);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        pend_d  = '0;
        out_d   = out_q;
        valid_d = '0;
        err_d   = err_q;

        if (en) begin
            if (LSB_FIRST) begin
                shift_d = {i_SO, shift_q[12:1]};
            end else begin
                shift_d = {shift_q[11:0], i_SO};
            end
            sh_d = sh_in;
            if (any_fall) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 5'd1;
            end
        end

        // Frame is captured on the fall; decoding happens one edge later from the holding register.
        for (int ch = 0; ch < 2; ch++) begin
            if (fall[ch] && accept) begin
                hold_d[ch] = shift_d;
                pend_d[ch] = 1'b1;
            end
            if (pend_q[ch]) begin
                out_d[ch]   = decode(hold_q[ch]);
                valid_d[ch] = 1'b1;
            end
        end

        if (i_ERR_CLR) begin
            err_d = 1'b0;
        end
        if (any_fall && !accept) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            sh_q    <= 2'b11;
            hold_q  <= '0;
            pend_q  <= '0;
            out_q   <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_L         = out_q[0];
    assign o_R         = out_q[1];
    assign o_L_VALID   = valid_q[0];
    assign o_R_VALID   = valid_q[1];
    assign o_FRAME_ERR = err_q;

`ifdef IKA2151_DAC_MONO_MIX_EN
    logic [16:0] mono_sum;
    logic [15:0] mono_q, mono_d;
    logic        mono_valid_q, mono_valid_d;

    always_comb begin
        mono_sum     = {out_q[0][15], out_q[0]} + {out_q[1][15], out_q[1]};
        mono_d       = mono_q;
        mono_valid_d = |valid_q;
        if (|valid_q) begin
            mono_d = mono_sum[16:1];
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            mono_q       <= '0;
            mono_valid_q <= 1'b0;
        end else begin
            mono_q       <= mono_d;
            mono_valid_q <= mono_valid_d;
        end
    end

    assign o_MONO       = mono_q;
    assign o_MONO_VALID = mono_valid_q;
`endif

endmodule

// File: tb/tb_ika2151_dac_deser.sv
// Randomized self-checking bench for ika2151_dac_deser: two instances (default params, and
// EXP0_MUTE=0 / MSB-first) share timing and are checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_ika2151_dac_deser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, nc_n, so_a, so_b, sh1, sh2, err_clr;
    logic [15:0] l_a, r_a, l_b, r_b;
    logic lv_a, rv_a, lv_b, rv_b, err_a, err_b;
`ifdef IKA2151_DAC_MONO_MIX_EN
    logic [15:0] mono_a, mono_b;
    logic mv_a, mv_b;
`endif

    ika2151_dac_deser dut_a (
        .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(nc_n), .i_SO(so_a),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(err_clr),
        .o_L(l_a), .o_L_VALID(lv_a), .o_R(r_a), .o_R_VALID(rv_a),
`ifdef IKA2151_DAC_MONO_MIX_EN
        .o_MONO(mono_a), .o_MONO_VALID(mv_a),
`endif
        .o_FRAME_ERR(err_a)
    );

    ika2151_dac_deser #(.EXP0_MUTE(1'b0), .LSB_FIRST(1'b0)) dut_b (
        .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(nc_n), .i_SO(so_b),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(err_clr),
        .o_L(l_b), .o_L_VALID(lv_b), .o_R(r_b), .o_R_VALID(rv_b),
`ifdef IKA2151_DAC_MONO_MIX_EN
        .o_MONO(mono_b), .o_MONO_VALID(mv_b),
`endif
        .o_FRAME_ERR(err_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit bits_a[$];
    bit bits_b[$];
    int m_cnt;
    bit m_sh1, m_sh2, m_err, lat_l, lat_r;
    logic [15:0] m_l_a, m_r_a, m_l_b, m_r_b, m_mono_a, m_mono_b;

    // Value of the 10-bit offset-binary mantissa times 2^(E-1)
    function automatic logic [15:0] dec(input logic [12:0] f, input bit mute);
        int e, s, v;
        e = int'(f[12:10]);
        s = int'(f[9:0]) - 512;
        if (e == 0) begin
            if (mute) return 16'h0000;
            e = 1;
        end
        v = s * (1 << (e - 1));
        return v[15:0];
    endfunction

    function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        s = s >>> 1;
        return s[15:0];
    endfunction

    // Frame = the last 13 bits received; bit weights depend on arrival order.
    function automatic logic [12:0] frame_of(input bit msb_first);
        int n, v;
        bit b;
        v = 0;
        n = msb_first ? bits_b.size() : bits_a.size();
        for (int k = 0; k < 13; k++) begin
            if (k < n) begin
                b = msb_first ? bits_b[n-1-k] : bits_a[n-1-k];
                if (b) v += msb_first ? (1 << k) : (1 << (12 - k));
            end
        end
        return v[12:0];
    endfunction

    task automatic model_reset();
        bits_a.delete(); bits_b.delete();
        m_cnt = 0; m_sh1 = 1; m_sh2 = 1; m_err = 0; lat_l = 0; lat_r = 0;
        m_l_a = 0; m_r_a = 0; m_l_b = 0; m_r_b = 0; m_mono_a = 0; m_mono_b = 0;
    endtask

    task automatic en_cycle(input bit ba, input bit bb, input bit s1, input bit s2, input bit clr);
        int gap;
        bit f1, f2;
        logic [12:0] fa, fb;
        gap = $urandom_range(0, 2);
        nc_n = 1; err_clr = 0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        so_a = ba; so_b = bb; sh1 = s1; sh2 = s2; err_clr = clr; nc_n = 0;
        @(posedge clk);
        f1 = m_sh1 && !s1;
        f2 = m_sh2 && !s2;
        bits_a.push_back(ba); bits_b.push_back(bb);
        if (bits_a.size() > 13) void'(bits_a.pop_front());
        if (bits_b.size() > 13) void'(bits_b.pop_front());
        if (clr) m_err = 0;
        if (f1 || f2) begin
            if (m_cnt >= 12) begin
                fa = frame_of(1'b0);
                fb = frame_of(1'b1);
                if (f1) begin m_l_a = dec(fa, 1'b1); m_l_b = dec(fb, 1'b0); lat_l = 1; end
                if (f2) begin m_r_a = dec(fa, 1'b1); m_r_b = dec(fb, 1'b0); lat_r = 1; end
            end else begin
                m_err = 1;
            end
            m_cnt = 0;
        end else if (m_cnt < 31) begin
            m_cnt++;
        end
        m_sh1 = s1; m_sh2 = s2;
        #1;
        nc_n = 1; err_clr = 0;
    endtask

    // Sends nbits; the last 13 carry frame f, and the final bit coincides with the SH fall(s).
    task automatic send_frame(input logic [12:0] f, input int nbits, input bit s1, input bit s2,
                              input bit clr_last, input string tag);
        int j;
        bit ba, bb, last;
        for (int i = 0; i < nbits; i++) begin
            j = i - (nbits - 13);
            ba = (j >= 0) ? f[j] : 1'($urandom_range(0, 1));
            bb = (j >= 0) ? f[12 - j] : 1'($urandom_range(0, 1));
            last = (i == nbits - 1);
            en_cycle(ba, bb, last ? !s1 : 1'b1, last ? !s2 : 1'b1, last && clr_last);
        end
        @(posedge clk); #1;
        $display("frame %s: f=%h bits=%0d sh1=%0d sh2=%0d -> L=%h/%h R=%h/%h err=%0d",
                 tag, f, nbits, s1, s2, l_a, l_b, r_a, r_b, err_a);
        n_vec++; if (lv_a !== lat_l) begin n_err++; $display("FAIL %s L_VALID(a) got=%b exp=%b", tag, lv_a, lat_l); end
        n_vec++; if (rv_a !== lat_r) begin n_err++; $display("FAIL %s R_VALID(a) got=%b exp=%b", tag, rv_a, lat_r); end
        n_vec++; if (lv_b !== lat_l) begin n_err++; $display("FAIL %s L_VALID(b) got=%b exp=%b", tag, lv_b, lat_l); end
        n_vec++; if (rv_b !== lat_r) begin n_err++; $display("FAIL %s R_VALID(b) got=%b exp=%b", tag, rv_b, lat_r); end
        n_vec++; if (l_a !== m_l_a) begin n_err++; $display("FAIL %s o_L(a) got=%h exp=%h", tag, l_a, m_l_a); end
        n_vec++; if (r_a !== m_r_a) begin n_err++; $display("FAIL %s o_R(a) got=%h exp=%h", tag, r_a, m_r_a); end
        n_vec++; if (l_b !== m_l_b) begin n_err++; $display("FAIL %s o_L(b) got=%h exp=%h", tag, l_b, m_l_b); end
        n_vec++; if (r_b !== m_r_b) begin n_err++; $display("FAIL %s o_R(b) got=%h exp=%h", tag, r_b, m_r_b); end
        n_vec++; if (err_a !== m_err || err_b !== m_err) begin
            n_err++; $display("FAIL %s FRAME_ERR got=%b/%b exp=%b", tag, err_a, err_b, m_err);
        end
        @(posedge clk); #1;
        n_vec++; if ({lv_a, rv_a, lv_b, rv_b} !== 4'b0000) begin
            n_err++; $display("FAIL %s VALID width got=%b%b%b%b exp=0000", tag, lv_a, rv_a, lv_b, rv_b);
        end
`ifdef IKA2151_DAC_MONO_MIX_EN
        if (lat_l || lat_r) begin
            m_mono_a = mix(m_l_a, m_r_a);
            m_mono_b = mix(m_l_b, m_r_b);
        end
        n_vec++; if (mv_a !== (lat_l | lat_r) || mv_b !== (lat_l | lat_r)) begin
            n_err++; $display("FAIL %s MONO_VALID got=%b/%b exp=%b", tag, mv_a, mv_b, lat_l | lat_r);
        end
        n_vec++; if (mono_a !== m_mono_a || mono_b !== m_mono_b) begin
            n_err++; $display("FAIL %s o_MONO got=%h/%h exp=%h/%h", tag, mono_a, mono_b, m_mono_a, m_mono_b);
        end
`endif
        lat_l = 0; lat_r = 0;
    endtask

    task automatic test_reset();
        n_vec++; if ({l_a, r_a, l_b, r_b} !== 64'h0 || {lv_a, rv_a, lv_b, rv_b, err_a, err_b} !== 6'h0) begin
            n_err++; $display("FAIL reset outputs got L=%h R=%h v=%b%b err=%b exp all 0", l_a, r_a, lv_a, rv_a, err_a);
        end
`ifdef IKA2151_DAC_MONO_MIX_EN
        n_vec++; if ({mono_a, mono_b, mv_a, mv_b} !== 34'h0) begin
            n_err++; $display("FAIL reset mono got=%h/%h exp=0", mono_a, mono_b);
        end
`endif
        $display("reset: outputs L=%h R=%h err=%b", l_a, r_a, err_a);
    endtask

    task automatic test_directed();
        send_frame({3'd7, 10'h3FF}, 13, 1, 0, 0, "E7_M3FF_L");
        n_vec++; if (l_a !== 16'h7FC0) begin n_err++; $display("FAIL max_pos o_L got=%h exp=7fc0", l_a); end
        n_vec++; if (r_a !== 16'h0000) begin n_err++; $display("FAIL max_pos o_R got=%h exp=0000", r_a); end
        send_frame({3'd7, 10'h000}, 13, 0, 1, 0, "E7_M000_R");
        n_vec++; if (r_a !== 16'h8000) begin n_err++; $display("FAIL max_neg o_R got=%h exp=8000", r_a); end
        send_frame({3'd1, 10'h201}, 13, 0, 1, 0, "E1_M201_R");
        n_vec++; if (r_a !== 16'h0001) begin n_err++; $display("FAIL e1 o_R got=%h exp=0001", r_a); end
        send_frame({3'd0, 10'h3FF}, 13, 1, 0, 0, "E0_M3FF_L");
        n_vec++; if (l_a !== 16'h0000 || l_b !== 16'h01FF) begin
            n_err++; $display("FAIL exp0 o_L got=%h/%h exp=0000/01ff", l_a, l_b);
        end
    endtask

    task automatic test_short_frame();
        send_frame(13'h1ABC, 8, 1, 0, 0, "short8");
        err_clr = 1; @(posedge clk); #1; err_clr = 0; m_err = 0;
        n_vec++; if (err_a !== 1'b0 || err_b !== 1'b0) begin
            n_err++; $display("FAIL err_clr got=%b/%b exp=0", err_a, err_b);
        end
        send_frame(13'h0F0F, 12, 0, 1, 0, "short12");
        send_frame(13'h1234, 5, 1, 0, 1, "short5_clr");
        err_clr = 1; @(posedge clk); #1; err_clr = 0; m_err = 0;
        send_frame(13'h1555, 13, 1, 0, 0, "full13");
    endtask

    task automatic test_both();
        send_frame({3'd4, 10'h2F0}, 13, 1, 1, 0, "E4_M2F0_both");
        send_frame(13'h1FFF, 13, 1, 1, 0, "both_max");
    endtask

    task automatic test_sh_held_low();
        send_frame(13'h0AAA, 13, 1, 0, 0, "pre_hold");
        for (int i = 0; i < 40; i++) en_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 0);
        @(posedge clk); #1;
        n_vec++; if ({lv_a, rv_a, lv_b, rv_b} !== 4'b0000) begin
            n_err++; $display("FAIL held_low VALID got=%b%b exp=00", lv_a, rv_a);
        end
        send_frame(13'h1357, 5, 1, 0, 0, "after_hold5");
    endtask

    task automatic test_mid_reset();
        send_frame(13'h0123, 8, 1, 0, 0, "pre_rst_err");
        for (int i = 0; i < 6; i++) en_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        n_vec++; if ({l_a, r_a, l_b, r_b} !== 64'h0 || {err_a, err_b} !== 2'b00) begin
            n_err++; $display("FAIL async_rst got L=%h R=%h err=%b exp 0", l_a, r_a, err_a);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({l_a, r_a, lv_a, rv_a, err_a} !== 35'h0) begin
            n_err++; $display("FAIL during_rst got L=%h R=%h err=%b exp 0", l_a, r_a, err_a);
        end
        #2 rst_n = 1;
        @(posedge clk); #1;
        send_frame({3'd3, 10'h155}, 13, 1, 0, 0, "post_rst");
    endtask

    task automatic test_random();
        logic [12:0] f;
        int nb, sel, pick;
        for (int i = 0; i < 40; i++) begin
            f = 13'($urandom);
            pick = $urandom_range(0, 9);
            nb = (pick < 6) ? 13 : (pick < 8) ? $urandom_range(14, 16) : $urandom_range(9, 12);
            sel = $urandom_range(1, 3);
            send_frame(f, nb, sel[0], sel[1], ($urandom_range(0, 7) == 0), "rand");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; nc_n = 1; so_a = 0; so_b = 0; sh1 = 1; sh2 = 1; err_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #2 rst_n = 1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_short_frame();
        test_both();
        test_sh_held_low();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
